uart_rx_byte: RTL and testbench
===============================

Name: uart_rx_byte

Overview:
- UART 8N1 receiver directly upstream of the serial-debug command scanner.
- Recovers bytes from the asynchronous `rxd` pin and presents each one on `d_rx`/`vld_rx`, with a `rdy_rx` back-pressure handshake.
- Provides a single-entry holding register. Reports overrun and framing errors as one-cycle pulses to the debug controller.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- DIV (localparam), CLK_FREQ/BAUD, clocks per bit. Must be >= 4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset. Synchronous, active-high.
- rxd  input  1  asynchronous serial line; idle high.
- d_rx  output  8  received byte; stable while `vld_rx`=1.
- vld_rx  output  1  byte available.
- rdy_rx  input  1  consumer ready. A transfer occurs on a rising edge with `vld_rx`&`rdy_rx`=1.
- ovr_err  output  1  one-cycle pulse: byte dropped, holding register full.
- frm_err  output  1  one-cycle pulse: stop bit sampled low (or parity bad, see feature).

Behaviour:
- Interface: one clock (`clk`); reset is synchronous and active-high (`rst`).
- Reset values: `d_rx`=0x00, `vld_rx`=0, `ovr_err`=0, `frm_err`=0, synchronizer flops=1, state=IDLE, counters=0.
- Reset takes effect in the same cycle it is sampled, including mid-frame. Any partial byte is discarded.
- `rxd` passes through a 2-flop synchronizer (`rxd_s`). All decisions use `rxd_s`.
- Bit counter `cnt`: counts 0..DIV-1. Bit index `bi`: 3 bits.
- IDLE: on `rxd_s`=0, go to START with `cnt`=0.
- START: at `cnt`=DIV/2-1, sample `rxd_s`.
  - 0: go to DATA, `cnt`=0, `bi`=0.
  - 1: glitch; return to IDLE with no output.
- DATA: at `cnt`=DIV-1, shift `rxd_s` into `shreg[bi]` (LSB first). At `bi`=7, go to STOP; otherwise `bi`++.
- STOP: at `cnt`=DIV-1, sample `rxd_s`.
  - 1: deliver the byte, go to IDLE.
  - 0: pulse `frm_err`, drop the byte, go to BREAK.
- BREAK: wait for `rxd_s`=1, then go to IDLE. This prevents a held-low line from re-triggering.
- Deliver, on the stop-sample edge:
  - Load condition: `vld_rx`=0, or `vld_rx`&`rdy_rx` in the same cycle.
  - If loadable: `d_rx` <= shreg, `vld_rx` <= 1.
  - Otherwise: keep the old `d_rx`/`vld_rx`, pulse `ovr_err`, and drop the new byte.
- Consume: `vld_rx`&`rdy_rx` with no simultaneous delivery → `vld_rx` <= 0. `d_rx` holds its last value.
- Latency: `vld_rx` rises 2 + DIV/2 + 9·DIV clocks after the falling edge of `rxd`, ±1 clock of edge uncertainty.
- `rdy_rx` is never required to be combinationally dependent on `vld_rx`. No combinational path exists from `rdy_rx` to any output.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples the 9th bit at `cnt`=DIV-1.
  - Parity is even over data+parity.
  - On mismatch: pulse `frm_err` after the stop bit is sampled high, and do not deliver the byte.
  - Latency grows by DIV.
- Undefined: no PARITY state; the frame is 8N1 as above.

Decomposition:
- Package `uart_pkg`:
  - State encoding: IDLE, START, DATA, PARITY, STOP, BREAK.
  - Function computing DIV from CLK_FREQ/BAUD.
  - Constants DATA_BITS=8 and LINE_IDLE=1'b1.
- Sub-module `sync_2ff`: generic 2-flop synchronizer with a reset value parameter. It is instantiated once for `rxd`.

Test Plan:
- Bench setup: CLK_FREQ=16, BAUD=1 (DIV=16), `rdy_rx` held 1.
- Single byte: drive frame 0x41 → `vld_rx`=1 with `d_rx`=0x41 at 2+8+144 clocks after the start edge; drops the cycle after `rdy_rx`.
- Glitch: `rxd` low for 4 clocks, then high → no `vld_rx`, no `frm_err`; the next frame 0x5A is received correctly.
- Overrun: `rdy_rx`=0, send 0x31 then 0x32.
  - `d_rx` stays 0x31, `vld_rx`=1, `ovr_err` pulses once.
  - Raising `rdy_rx` consumes 0x31 and `vld_rx` falls.
  - Simultaneous consume+deliver loads the new byte with no pulse.
- Framing: send 0x0D with the stop bit low for 3·DIV, then idle → one `frm_err` pulse, no `vld_rx`; the following 0x0A is received.
- Reset mid-frame: assert `rst` at bit 4 of 0x77 for 1 cycle, then send 0x20 → only 0x20 delivered, all outputs reset the cycle after `rst`.
- Parity (macro defined): 0x07 with parity=1 → delivered; 0x07 with parity=0 → `frm_err`, no `vld_rx`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_rx_byte receiver: FSM state
// encoding, frame constants and the clocks-per-bit helper.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_state_t;

  // Clocks per bit; callers must keep the result >= 4 so the half-bit
  // sample point lands strictly inside the start bit.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level, with a
// configurable value loaded by the synchronous active-high reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // NOTE: both stages reset to the line's idle level so a reset never
  // fabricates a falling edge that the receiver would take as a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_byte.sv
// UART 8N1 receiver with a single-entry holding register and valid/ready
// output. Define UART_RX_PARITY_EN to add an even-parity bit after the data.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] d_rx,
  output logic       vld_rx,
  input  logic       rdy_rx,
  output logic       ovr_err,
  output logic       frm_err
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [2:0]       BI_LAST  = 3'(DATA_BITS - 1);

  logic w_rxd_s;
  logic w_take;

  uart_state_t            r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [2:0]             r_bi;
  logic [DATA_BITS-1:0]   r_shreg;
  logic [7:0]             r_d_rx;
  logic                   r_vld_rx;
  logic                   r_ovr_err;
  logic                   r_frm_err;
`ifdef UART_RX_PARITY_EN
  logic                   r_par_bad;
`endif

  sync_2ff #(.RST_VAL(LINE_IDLE)) u_sync_rxd (
    .clk (clk),
    .rst (rst),
    .i_d (rxd),
    .o_q (w_rxd_s)
  );

  assign w_take = r_vld_rx & rdy_rx;

  // NOTE: the consume clear is written before the FSM so that a delivery in
  // the same cycle, assigned later with <=, wins and keeps vld_rx high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bi      <= '0;
      r_shreg   <= '0;
      r_d_rx    <= '0;
      r_vld_rx  <= 1'b0;
      r_ovr_err <= 1'b0;
      r_frm_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_ovr_err <= 1'b0;
      r_frm_err <= 1'b0;
      if (w_take) r_vld_rx <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_rxd_s != LINE_IDLE) r_state <= ST_START;
        end

        ST_START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt   <= '0;
            r_bi    <= '0;
            r_state <= (w_rxd_s == LINE_IDLE) ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt         <= '0;
            r_shreg[r_bi] <= w_rxd_s;
            if (r_bi == BI_LAST) begin
`ifdef UART_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end else begin
              r_bi <= r_bi + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt     <= '0;
            r_par_bad <= ^{r_shreg, w_rxd_s};
            r_state   <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`endif

        ST_STOP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (w_rxd_s != LINE_IDLE) begin
              r_frm_err <= 1'b1;
              r_state   <= ST_BREAK;
            end else begin
              r_state <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
              if (r_par_bad) begin
                r_frm_err <= 1'b1;
              end else
`endif
              if (!r_vld_rx || w_take) begin
                r_d_rx   <= r_shreg;
                r_vld_rx <= 1'b1;
              end else begin
                r_ovr_err <= 1'b1;
              end
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        // A line held low after a bad stop bit must go idle before re-arming.
        ST_BREAK: begin
          r_cnt <= '0;
          if (w_rxd_s == LINE_IDLE) r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign d_rx    = r_d_rx;
  assign vld_rx  = r_vld_rx;
  assign ovr_err = r_ovr_err;
  assign frm_err = r_frm_err;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte at DIV=16; exercises the parity
// cases as well when UART_RX_PARITY_EN is defined.
module tb_uart_rx_byte;

  localparam int CLK_FREQ = 16;
  localparam int BAUD     = 1;
  localparam int DIV      = 16;
`ifdef UART_RX_PARITY_EN
  localparam int EXTRA    = 1;
`else
  localparam int EXTRA    = 0;
`endif
  localparam int LAT_NOM  = 2 + DIV / 2 + 9 * DIV + EXTRA * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] d_rx;
  logic       vld_rx;
  logic       rdy_rx;
  logic       ovr_err;
  logic       frm_err;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int ovr_cnt   = 0;
  int frm_cnt   = 0;
  int deliv_cnt = 0;
  int rise_cyc  = -1;
  logic vld_q   = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk     (clk),
    .rst     (rst),
    .rxd     (rxd),
    .d_rx    (d_rx),
    .vld_rx  (vld_rx),
    .rdy_rx  (rdy_rx),
    .ovr_err (ovr_err),
    .frm_err (frm_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every transfer seen on the interface pops one byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (ovr_err) ovr_cnt++;
      if (frm_err) frm_cnt++;
      if (vld_rx && !vld_q) rise_cyc = cyc;
      if (vld_rx && rdy_rx) begin
        deliv_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_unexpected: observed byte 0x%0h expected none", d_rx);
        end else begin
          check("sb_byte", {24'd0, d_rx}, {24'd0, exp_q.pop_front()});
        end
      end
    end
    vld_q = vld_rx;
  end

  task automatic drive_bit(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame; stop_low > 0 holds the stop bit low that many clocks first.
  task automatic send_frame(input logic [7:0] data, input logic par_flip,
                            input int stop_low, output int c0);
    @(posedge clk);
    #1;
    c0 = cyc;
    drive_bit(1'b0, DIV);
    for (int i = 0; i < 8; i++) drive_bit(data[i], DIV);
`ifdef UART_RX_PARITY_EN
    drive_bit((^data) ^ par_flip, DIV);
`endif
    if (stop_low > 0) drive_bit(1'b0, stop_low);
    drive_bit(1'b1, DIV);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int d0;
    int o0;
    int f0;
    logic [7:0] mid;

    rst    = 1'b1;
    rxd    = 1'b1;
    rdy_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_d_rx", {24'd0, d_rx}, 32'h00);
    check("rst_vld", {31'd0, vld_rx}, 32'd0);
    check("rst_ovr", {31'd0, ovr_err}, 32'd0);
    check("rst_frm", {31'd0, frm_err}, 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // Single byte with latency window.
    rise_cyc = -1;
    exp_q.push_back(8'h41);
    send_frame(8'h41, 1'b0, 0, c0);
    check("lat_in_window",
          {31'd0, (rise_cyc - c0 >= LAT_NOM) && (rise_cyc - c0 <= LAT_NOM + 2)}, 32'd1);
    check("single_vld_dropped", {31'd0, vld_rx}, 32'd0);
    check("single_deliv", deliv_cnt, 32'd1);

    // Start-bit glitch.
    d0 = deliv_cnt;
    f0 = frm_cnt;
    @(posedge clk);
    #1;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 2 * DIV);
    check("glitch_no_deliv", deliv_cnt, d0);
    check("glitch_no_frm", frm_cnt, f0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 0, c0);
    check("glitch_next_deliv", deliv_cnt, d0 + 1);

    // Overrun: holding register full drops the second byte.
    rdy_rx = 1'b0;
    o0 = ovr_cnt;
    exp_q.push_back(8'h31);
    send_frame(8'h31, 1'b0, 0, c0);
    send_frame(8'h32, 1'b0, 0, c0);
    repeat (2) @(posedge clk);
    #1;
    check("ovr_d_rx_kept", {24'd0, d_rx}, 32'h31);
    check("ovr_vld_held", {31'd0, vld_rx}, 32'd1);
    check("ovr_one_pulse", ovr_cnt, o0 + 1);
    rdy_rx = 1'b1;
    @(posedge clk);
    #1;
    rdy_rx = 1'b0;
    check("ovr_consumed_vld_low", {31'd0, vld_rx}, 32'd0);

    // Consume and deliver on the same edge: new byte loads, no overrun.
    exp_q.push_back(8'h33);
    send_frame(8'h33, 1'b0, 0, c0);
    exp_q.push_back(8'h34);
    o0 = ovr_cnt;
    fork
      send_frame(8'h34, 1'b0, 0, c0);
      begin
        @(posedge clk);
        repeat (LAT_NOM) @(posedge clk);
        #1;
        rdy_rx = 1'b1;
        @(posedge clk);
        #1;
        rdy_rx = 1'b0;
      end
    join
    check("simul_vld", {31'd0, vld_rx}, 32'd1);
    check("simul_d_rx", {24'd0, d_rx}, 32'h34);
    check("simul_no_ovr", ovr_cnt, o0);
    rdy_rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("simul_drained", exp_q.size(), 32'd0);

    // Framing error with the line held low past the stop bit.
    d0 = deliv_cnt;
    f0 = frm_cnt;
    send_frame(8'h0D, 1'b0, 3 * DIV, c0);
    check("frm_one_pulse", frm_cnt, f0 + 1);
    check("frm_no_deliv", deliv_cnt, d0);
    exp_q.push_back(8'h0A);
    send_frame(8'h0A, 1'b0, 0, c0);
    check("frm_next_deliv", deliv_cnt, d0 + 1);

    // Reset during bit 4 of 0x77.
    d0  = deliv_cnt;
    mid = 8'h77;
    @(posedge clk);
    #1;
    drive_bit(1'b0, DIV);
    for (int i = 0; i < 4; i++) drive_bit(mid[i], DIV);
    drive_bit(mid[4], DIV / 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_d_rx", {24'd0, d_rx}, 32'h00);
    check("midrst_vld", {31'd0, vld_rx}, 32'd0);
    check("midrst_ovr", {31'd0, ovr_err}, 32'd0);
    check("midrst_frm", {31'd0, frm_err}, 32'd0);
    rst = 1'b0;
    drive_bit(1'b1, 2 * DIV);
    exp_q.push_back(8'h20);
    send_frame(8'h20, 1'b0, 0, c0);
    check("midrst_only_new", deliv_cnt, d0 + 1);

`ifdef UART_RX_PARITY_EN
    d0 = deliv_cnt;
    f0 = frm_cnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b0, 0, c0);
    check("par_good_deliv", deliv_cnt, d0 + 1);
    send_frame(8'h07, 1'b1, 0, c0);
    check("par_bad_frm", frm_cnt, f0 + 1);
    check("par_bad_no_deliv", deliv_cnt, d0 + 1);
`endif

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty_at_end", exp_q.size(), 32'd0);
    check("vld_idle_at_end", {31'd0, vld_rx}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
